mod_regread: RTL
================

MOD_REGREAD -- requirements
Module: mod_regread

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset; all state is clocked on the rising edge of clk.
REQ-002 SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- id_valid  in  1  decode presents an instruction
- id_ready  out  1  stage accepts the instruction this cycle
- id_srcA_en, id_srcB_en  in  1 each  source A / B read enables
- id_srcA, id_srcB  in  4 each  source register indices
- id_dst_mask  in  16  registers this instruction will write (bit 4 = RSP, bit 2 = RDX)
- id_ctl  in  64  opaque control bundle (opcode, twob_opcode, mod, regByte, rmByte), passed through
- rf_data  in  16x64  current architectural register file contents
- wb_done_valid  in  1  writeback retired a producer
- wb_done_mask  in  16  busy bits to clear
- flush  in  1  drop the held instruction and clear all busy bits
- rr_valid  out  1  output register holds an instruction
- rr_ready  in  1  downstream accepts
- rr_opA, rr_opB  out  64 each  captured operands
- rr_dst_mask  out  16  registered copy of id_dst_mask
- rr_ctl  out  64  registered copy of id_ctl
- sb_busy  out  16  scoreboard state
- stall_cnt  out  16  count of hazard-stall cycles
- sb_err  out  1  sticky error flag

Function
REQ-003 SHALL keep a 16-bit scoreboard busy[i]; bit i = 1 means an issued, unretired instruction will write register i.
REQ-004 SHALL define a hazard as: (srcA_en and busy[srcA]) or (srcB_en and busy[srcB]) or (id_dst_mask AND busy) != 0 (WAW).
REQ-005 SHALL drive id_ready = !hazard && (!rr_valid || rr_ready) && !flush, combinationally.
REQ-006 SHALL issue on id_valid && id_ready: on the same edge, load rr_opA = srcA_en ? rf_data[srcA] : 0, rr_opB likewise, rr_dst_mask, rr_ctl, and set rr_valid = 1. Latency is 1 cycle.
REQ-007 SHALL compute busy_next = (busy AND NOT clear) OR set, where clear = wb_done_valid ? wb_done_mask : 0 and set = issue ? id_dst_mask : 0; when a bit is both set and cleared in the same cycle, set wins.
REQ-008 SHALL NOT bypass: a busy bit cleared in cycle N unblocks the waiting instruction no earlier than cycle N+1, when rf_data already holds the written value.
REQ-009 SHALL clear rr_valid on rr_valid && rr_ready && !issue, and SHALL hold all rr_* outputs stable while rr_valid && !rr_ready.
REQ-010 SHALL implement an FSM with three states:
- EMPTY: rr_valid = 0
- FULL: rr_valid = 1, no hazard pending
- STALL: id_valid && hazard

Transitions are evaluated each cycle from rr_valid and hazard after the edge. STALL takes priority over FULL when reporting.
REQ-011 SHALL increment stall_cnt by 1 in each cycle where id_valid && hazard, saturating at 16'hFFFF.
REQ-012 SHALL, on flush, force rr_valid = 0, busy = 0, and state = EMPTY on the next edge; flush overrides any issue or clear in the same cycle. stall_cnt is unaffected.
REQ-013 SHALL set sb_err (sticky until reset) when wb_done_valid clears any bit that is not busy, or when issue occurs with id_dst_mask = 0 while id_ctl[0:7] (opcode) is 80-95. The clear is still applied.
REQ-014 SHALL treat an instruction with id_dst_mask = 0 as never causing WAW and never setting busy bits.

Reset
REQ-015 SHALL, while reset = 0, asynchronously force rr_valid = 0, rr_opA = rr_opB = 0, rr_ctl = 0, rr_dst_mask = 0, busy = 0, stall_cnt = 0, sb_err = 0, and state = EMPTY.
REQ-016 SHALL, when reset asserts mid-stall or mid-hold, discard the held instruction with no partial busy update; id_ready SHALL be 0 while reset = 0.

Verification
REQ-017 Stimulus: rf_data[3] = 64'h11, issue srcA = 3, dst_mask = 16'h0001, rr_ready = 1. Response: next cycle rr_valid = 1, rr_opA = 64'h11, sb_busy = 16'h0001.
REQ-018 Stimulus: RAW on register 0, with wb_done_mask = 16'h0001 pulsed in cycle N. Response: stall_cnt increments each waiting cycle; id_ready = 1 at N+1, not at N; operand equals the post-write rf_data[0].
REQ-019 Stimulus: issue with dst bit 4 in the same cycle as a wb clear of bit 4. Response: sb_busy[4] = 1.
REQ-020 Stimulus: rr_ready = 0 for 3 cycles with id_valid = 1. Response: rr_* stable and id_ready = 0 throughout; on release, one transfer per cycle.
REQ-021 Stimulus: flush while busy = 16'h0011 and rr_valid = 1. Response: next cycle busy = 0 and rr_valid = 0. Separately, a wb clear of a non-busy bit drives sb_err = 1, which persists until reset.
REQ-022 Stimulus: assert reset mid-stall. Response: all outputs at their REQ-015 values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mod_regread_if.sv
// Register-read stage bus: decode-side request, register file view,
// writeback retire, flush, and the registered operand output.
interface mod_regread_if;
   logic                 id_valid;
   logic                 id_ready;
   logic                 id_srcA_en;
   logic                 id_srcB_en;
   logic [3:0]           id_srcA;
   logic [3:0]           id_srcB;
   logic [15:0]          id_dst_mask;
   logic [63:0]          id_ctl;
   logic [15:0][63:0]    rf_data;
   logic                 wb_done_valid;
   logic [15:0]          wb_done_mask;
   logic                 flush;
   logic                 rr_valid;
   logic                 rr_ready;
   logic [63:0]          rr_opA;
   logic [63:0]          rr_opB;
   logic [15:0]          rr_dst_mask;
   logic [63:0]          rr_ctl;
   logic [15:0]          sb_busy;
   logic [15:0]          stall_cnt;
   logic                 sb_err;

   modport slave (
      input  id_valid, id_srcA_en, id_srcB_en, id_srcA, id_srcB,
      input  id_dst_mask, id_ctl, rf_data,
      input  wb_done_valid, wb_done_mask, flush, rr_ready,
      output id_ready, rr_valid, rr_opA, rr_opB, rr_dst_mask,
      output rr_ctl, sb_busy, stall_cnt, sb_err
   );

   modport master (
      output id_valid, id_srcA_en, id_srcB_en, id_srcA, id_srcB,
      output id_dst_mask, id_ctl, rf_data,
      output wb_done_valid, wb_done_mask, flush, rr_ready,
      input  id_ready, rr_valid, rr_opA, rr_opB, rr_dst_mask,
      input  rr_ctl, sb_busy, stall_cnt, sb_err
   );
endinterface

// File: rtl/mod_regread.sv
// Register-read stage with a busy-bit scoreboard: stalls on RAW/WAW,
// captures operands into a one-deep output register, no bypassing.
module mod_regread (
   input logic          clk,
   input logic          reset,
   mod_regread_if.slave bus
);

   typedef enum logic [1:0] {EMPTY, FULL, STALL} state_t;

   state_t      state_q, state_d;
   logic        valid_q;
   logic [63:0] opa_q, opb_q, ctl_q;
   logic [15:0] dst_q, busy_q, cnt_q;
   logic        err_q;

   logic        rr_valid;
   logic        hazard, stalled, issue;
   logic [15:0] clr, set;
   logic [7:0]  opcode;
   logic        op_flag;

   // Output register is live only while the FSM is out of EMPTY.
   assign rr_valid = valid_q && (state_q != EMPTY);

   // Hazard, handshake and scoreboard update terms.
   always_comb begin
      hazard = (bus.id_srcA_en && busy_q[bus.id_srcA])
            || (bus.id_srcB_en && busy_q[bus.id_srcB])
            || ((bus.id_dst_mask & busy_q) != '0);
      bus.id_ready = reset && !hazard
                  && (!rr_valid || bus.rr_ready) && !bus.flush;
      issue   = bus.id_valid && bus.id_ready;
      stalled = bus.id_valid && hazard;
      clr     = bus.wb_done_valid ? bus.wb_done_mask : '0;
      set     = issue ? bus.id_dst_mask : '0;
      opcode  = bus.id_ctl[7:0];
      op_flag = (opcode >= 8'd80) && (opcode <= 8'd95);
   end

   // Next-state: flush empties, a waiting hazard reports STALL first.
   always_comb begin
      state_d = state_q;
      if (bus.flush)
         state_d = EMPTY;
      else if (stalled)
         state_d = STALL;
      else if (issue || (rr_valid && !bus.rr_ready))
         state_d = FULL;
      else
         state_d = EMPTY;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state_q <= EMPTY;
      else
         state_q <= state_d;
   end

   // Output register: load on issue, drop on transfer or flush.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q <= 1'b0;
         opa_q   <= '0;
         opb_q   <= '0;
         dst_q   <= '0;
         ctl_q   <= '0;
      end else if (bus.flush) begin
         valid_q <= 1'b0;
      end else if (issue) begin
         valid_q <= 1'b1;
         opa_q   <= bus.id_srcA_en ? bus.rf_data[bus.id_srcA] : '0;
         opb_q   <= bus.id_srcB_en ? bus.rf_data[bus.id_srcB] : '0;
         dst_q   <= bus.id_dst_mask;
         ctl_q   <= bus.id_ctl;
      end else if (rr_valid && bus.rr_ready) begin
         valid_q <= 1'b0;
      end
   end

   // Scoreboard: set wins over a same-cycle clear, flush wipes all.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         busy_q <= '0;
      else if (bus.flush)
         busy_q <= '0;
      else
         busy_q <= (busy_q & ~clr) | set;
   end

   // Saturating count of cycles spent waiting on a hazard.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt_q <= '0;
      else if (stalled && (cnt_q != 16'hFFFF))
         cnt_q <= cnt_q + 16'd1;
   end

   // Sticky error: retire of an idle bit, or a destination-less issue
   // of an opcode in the 80..95 range that should have a destination.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         err_q <= 1'b0;
      else if (((clr & ~busy_q) != '0)
            || (issue && (bus.id_dst_mask == '0) && op_flag))
         err_q <= 1'b1;
   end

   assign bus.rr_valid    = rr_valid;
   assign bus.rr_opA      = opa_q;
   assign bus.rr_opB      = opb_q;
   assign bus.rr_dst_mask = dst_q;
   assign bus.rr_ctl      = ctl_q;
   assign bus.sb_busy     = busy_q;
   assign bus.stall_cnt   = cnt_q;
   assign bus.sb_err      = err_q;

endmodule
